// File: rtl/axis_bp_pkg.sv
// rtl/axis_bp_pkg.sv - shared widths and LFSR step for the AXI-Stream back-pressure unit
// Purpose: stream data width, LFSR geometry/taps and the single-step LFSR function.
// Ports: none (package).
package axis_bp_pkg;

  localparam int AXIS_DATA_WIDTH = 32;
  localparam int LFSR_WIDTH      = 16;

  // Fibonacci taps 16,14,13,11 on a right-shifting register: the taps land on
  // bits 0,2,3,5 and the feedback bit enters at the MSB.
  localparam logic [LFSR_WIDTH-1:0] LFSR_TAP_MASK = 16'h002D;

  function automatic logic [LFSR_WIDTH-1:0] lfsr_next(input logic [LFSR_WIDTH-1:0] state);
    logic feedback;
    feedback = ^(state & LFSR_TAP_MASK);
    return {feedback, state[LFSR_WIDTH-1:1]};
  endfunction

endpackage

// File: rtl/axi_stream_simple_if.sv
// rtl/axi_stream_simple_if.sv - minimal AXI-Stream bus bundle (tdata/tvalid/tready)
// Purpose: carries one AXI-Stream link between a master and a slave.
// Ports: aclk - bus clock. Modports: master drives tdata/tvalid, slave drives tready.
interface axi_stream_simple_if
  import axis_bp_pkg::*;
#(
  parameter int DATA_WIDTH = AXIS_DATA_WIDTH
) (
  input logic aclk
);

  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;

  modport master (input aclk, output tdata, output tvalid, input tready);
  modport slave  (input aclk, input tdata, input tvalid, output tready);

endinterface

// File: rtl/axis_bp_lfsr.sv
// rtl/axis_bp_lfsr.sv - 16-bit Fibonacci LFSR stepping once per advance strobe
// Purpose: reproducible pseudo-random sequence source for per-beat delays.
// Ports: clk_i - clock; rst_ni - async active-low reset (loads SEED);
//        advance_i - step once on this edge; state_o - current register value.
module axis_bp_lfsr
  import axis_bp_pkg::*;
#(
  parameter logic [LFSR_WIDTH-1:0] SEED = 16'hACE1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  advance_i,
  output logic [LFSR_WIDTH-1:0] state_o
);

  logic [LFSR_WIDTH-1:0] state_q;
  logic [LFSR_WIDTH-1:0] state_d;

  always_comb begin
    state_d = state_q;
    if (advance_i) begin
      state_d = lfsr_next(state_q);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/sim_axis_back_pressure_unit.sv
// rtl/sim_axis_back_pressure_unit.sv - forwards AXI-Stream beats after a pseudo-random hold-off
// Purpose: passes every beat unchanged but stalls both directions for 0..MAX_DELAY_CYCLES
//          cycles before each beat so the producer sees back-pressure.
// Ports: clock_i - clock; reset_i - async active-low reset;
//        axis_s - upstream (tready driven here); axis_m - downstream (tdata/tvalid driven here).
module sim_axis_back_pressure_unit
  import axis_bp_pkg::*;
#(
  parameter int                    MAX_DELAY_CYCLES = 6,
  parameter logic [LFSR_WIDTH-1:0] SEED             = 16'hACE1
) (
  input  logic                       clock_i,
  input  logic                       reset_i,
  axi_stream_simple_if.slave         axis_s,
  axi_stream_simple_if.master        axis_m
);

  localparam int CNT_W = (MAX_DELAY_CYCLES > 0) ? $clog2(MAX_DELAY_CYCLES + 1) : 1;
  localparam logic [LFSR_WIDTH-1:0] MODULUS = LFSR_WIDTH'(MAX_DELAY_CYCLES + 1);
  localparam logic [CNT_W-1:0]      CNT_RST = CNT_W'(SEED % MODULUS);

  logic                  gate_open_q;
  logic                  gate_open_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      cnt_d;
  logic [LFSR_WIDTH-1:0] lfsr_state;
  logic [LFSR_WIDTH-1:0] lfsr_new;
  logic                  gate;
  logic                  handshake;

  axis_bp_lfsr #(
    .SEED (SEED)
  ) u_lfsr (
    .clk_i     (clock_i),
    .rst_ni    (reset_i),
    .advance_i (handshake),
    .state_o   (lfsr_state)
  );

  // A zero count opens the gate without waiting for gate_open_q, which is what
  // gives zero-delay beats their same-cycle pass-through.
  assign gate = gate_open_q | (cnt_q == '0);

  // reset_i gates the handshake outputs so they drop the instant reset asserts,
  // even when the reset count happens to be zero.
  assign axis_m.tdata  = axis_s.tdata;
  assign axis_m.tvalid = axis_s.tvalid & gate & reset_i;
  assign axis_s.tready = axis_m.tready & gate & reset_i;

  assign handshake = axis_s.tvalid & axis_s.tready;
  assign lfsr_new  = lfsr_next(lfsr_state);

  always_comb begin
    gate_open_d = gate_open_q;
    cnt_d       = cnt_q;
    if (handshake) begin
      // Next beat's delay comes from the value the LFSR steps to on this edge.
      cnt_d       = CNT_W'(lfsr_new % MODULUS);
      gate_open_d = 1'b0;
    end else if (!gate && axis_s.tvalid) begin
      // The delay only elapses while a beat is actually being offered.
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        gate_open_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      gate_open_q <= 1'b0;
      cnt_q       <= CNT_RST;
    end else begin
      gate_open_q <= gate_open_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_sim_axis_back_pressure_unit.sv
// tb/tb_sim_axis_back_pressure_unit.sv - directed scoreboard bench for the back-pressure unit
module tb_sim_axis_back_pressure_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] s_tdata  [3];
  logic        s_tvalid [3];
  logic        m_tready [3];
  logic [31:0] m_tdata  [3];
  logic        m_tvalid [3];
  logic        s_tready [3];

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_data_q [$];
  int          exp_wait_q [$];
  logic [15:0] mstate [3];

  // Instance 0: defaults; 1: transparent; 2: SEED=1, MAX=3.
  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : gen_dut
      localparam int          MAXD = (g == 0) ? 6 : ((g == 1) ? 0 : 3);
      localparam logic [15:0] SD   = (g == 2) ? 16'h0001 : 16'hACE1;
      axi_stream_simple_if s_if (.aclk(clk));
      axi_stream_simple_if m_if (.aclk(clk));
      assign s_if.tdata  = s_tdata[g];
      assign s_if.tvalid = s_tvalid[g];
      assign m_if.tready = m_tready[g];
      assign m_tdata[g]  = m_if.tdata;
      assign m_tvalid[g] = m_if.tvalid;
      assign s_tready[g] = s_if.tready;
      sim_axis_back_pressure_unit #(
        .MAX_DELAY_CYCLES (MAXD),
        .SEED             (SD)
      ) dut (
        .clock_i (clk),
        .reset_i (rst_n),
        .axis_s  (s_if),
        .axis_m  (m_if)
      );
    end
  endgenerate

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  function automatic int mod_of(input int idx);
    return (idx == 0) ? 7 : ((idx == 1) ? 1 : 4);
  endfunction

  function automatic logic [15:0] seed_of(input int idx);
    return (idx == 2) ? 16'h0001 : 16'hACE1;
  endfunction

  // Reference LFSR: b = s ^ s>>2 ^ s>>3 ^ s>>5, shifted in at the top.
  function automatic logic [15:0] model_next(input logic [15:0] s);
    logic [15:0] b;
    b = (s ^ (s >> 2) ^ (s >> 3) ^ (s >> 5)) & 16'h0001;
    return (s >> 1) | (b << 15);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Called at a falling edge: offer a beat and record what must come out.
  task automatic start_beat(input int idx, input logic [31:0] data);
    s_tdata[idx]  = data;
    s_tvalid[idx] = 1'b1;
    exp_data_q.push_back(data);
    exp_wait_q.push_back(int'(mstate[idx] % 16'(mod_of(idx))));
  endtask

  // Counts falling edges until downstream tvalid appears; ends at negedge+1.
  task automatic wait_gate(input int idx, output int waits);
    waits = 0;
    #1;
    while (!m_tvalid[idx] && waits < 40) begin
      @(negedge clk);
      #1;
      waits++;
    end
    check("gate_open_tvalid", {31'd0, m_tvalid[idx]}, 32'd1);
  endtask

  // With tready high and the gate open, the handshake lands on the next edge.
  task automatic finish_beat(input int idx, input int waits);
    logic [31:0] ed;
    int          ew;
    ed = exp_data_q.pop_front();
    ew = exp_wait_q.pop_front();
    check("beat_tdata", m_tdata[idx], ed);
    check("beat_wait", 32'(waits), 32'(ew));
    check("beat_s_tready", {31'd0, s_tready[idx]}, 32'd1);
    @(negedge clk);
    s_tvalid[idx] = 1'b0;
    mstate[idx] = model_next(mstate[idx]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    int          w;
    int          ew;
    logic [31:0] held;

    for (int i = 0; i < 3; i++) begin
      s_tdata[i]  = 32'd0;
      s_tvalid[i] = 1'b1;
      m_tready[i] = 1'b1;
      mstate[i]   = seed_of(i);
    end
    rst_n = 1'b0;
    #12;
    for (int i = 0; i < 3; i++) begin
      check("reset_m_tvalid", {31'd0, m_tvalid[i]}, 32'd0);
      check("reset_s_tready", {31'd0, s_tready[i]}, 32'd0);
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) s_tvalid[i] = 1'b0;
    rst_n = 1'b1;
    #1;
    check("post_reset_a_s_tready", {31'd0, s_tready[0]}, 32'd0);
    check("post_reset_b_s_tready", {31'd0, s_tready[1]}, 32'd1);
    check("post_reset_c_s_tready", {31'd0, s_tready[2]}, 32'd0);
    @(negedge clk);

    // Default unit: three beats with idle gaps.
    for (int b = 1; b <= 3; b++) begin
      start_beat(0, 32'(b));
      wait_gate(0, w);
      check("beat_wait_range", {31'd0, (w <= 6)}, 32'd1);
      finish_beat(0, w);
      idle(3);
    end

    // Sink stalls for 10 cycles after the gate opens.
    m_tready[0] = 1'b0;
    start_beat(0, 32'hA5A5_0001);
    wait_gate(0, w);
    held = m_tdata[0];
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      check("stall_m_tvalid", {31'd0, m_tvalid[0]}, 32'd1);
      check("stall_m_tdata", m_tdata[0], held);
      check("stall_s_tready", {31'd0, s_tready[0]}, 32'd0);
    end
    @(negedge clk);
    m_tready[0] = 1'b1;
    #1;
    finish_beat(0, w);

    // Upstream idle for 20 cycles: nothing offered, delay must not elapse.
    for (int i = 0; i < 20; i++) begin
      #1;
      check("idle_m_tvalid", {31'd0, m_tvalid[0]}, 32'd0);
      check("idle_s_tready", {31'd0, s_tready[0]},
            {31'd0, ((mstate[0] % 16'd7) == 16'd0)});
      @(negedge clk);
    end
    start_beat(0, 32'h0000_0077);
    wait_gate(0, w);
    finish_beat(0, w);

    // Reset asserted between edges while a beat is about to be accepted.
    start_beat(0, 32'hBEEF_CAFE);
    wait_gate(0, w);
    ew = exp_wait_q.pop_front();
    check("pre_reset_wait", 32'(w), 32'(ew));
    check("pre_reset_s_tready", {31'd0, s_tready[0]}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset_m_tvalid", {31'd0, m_tvalid[0]}, 32'd0);
    check("async_reset_s_tready", {31'd0, s_tready[0]}, 32'd0);
    for (int i = 0; i < 3; i++) mstate[i] = seed_of(i);
    exp_wait_q.push_back(int'(mstate[0] % 16'd7));
    @(negedge clk);
    rst_n = 1'b1;
    wait_gate(0, w);
    finish_beat(0, w);

    // Transparent unit: ten back-to-back beats, one per cycle.
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      s_tdata[1]  = 32'(i);
      s_tvalid[1] = 1'b1;
      exp_data_q.push_back(32'(i));
      #1;
      check("wire_m_tdata", m_tdata[1], exp_data_q.pop_front());
      check("wire_m_tvalid", {31'd0, m_tvalid[1]}, 32'd1);
      check("wire_s_tready", {31'd0, s_tready[1]}, 32'd1);
      @(negedge clk);
    end
    s_tvalid[1] = 1'b0;
    m_tready[1] = 1'b0;
    #1;
    check("wire_s_tready_low", {31'd0, s_tready[1]}, 32'd0);
    @(negedge clk);

    // SEED=1, MAX=3: eight beats, delays follow the reference sequence mod 4.
    for (int b = 0; b < 8; b++) begin
      start_beat(2, 32'h0C00_0000 | 32'(b));
      wait_gate(2, w);
      finish_beat(2, w);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
